// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access unit with byte-lane
// steering, load extension, misalignment faults and pipeline stall.
module load_store_unit (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        valid_ex_i,
   input  logic        mem_read_ex_i,
   input  logic        mem_write_ex_i,
   input  logic [2:0]  funct3_ex_i,
   input  logic [31:0] alu_result_ex_i,
   input  logic [31:0] write_data_ex_i,
   input  logic [4:0]  rd_ex_i,
   input  logic        flush_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] load_data_o,
   output logic [4:0]  rd_o,
   output logic        load_valid_o,
   output logic        store_done_o,
   output logic        fault_o,
   output logic        stall_o
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t      r_state, w_next;
   logic [29:0] r_addr;
   logic [1:0]  r_off;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [2:0]  r_f3;
   logic [4:0]  r_rd;
   logic [31:0] r_load_data;
   logic [4:0]  r_rd_out;
   logic        r_load_valid;
   logic        r_store_done;
   logic        r_fault;

   logic        w_acc, w_legal, w_mis, w_f3ok;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_shift, w_ext;

   assign w_acc = (r_state == S_IDLE) & valid_ex_i & (mem_read_ex_i | mem_write_ex_i) & ~flush_i;
   assign w_mis = ((funct3_ex_i[1:0] == 2'b01) & alu_result_ex_i[0]) |
                  ((funct3_ex_i[1:0] == 2'b10) & (|alu_result_ex_i[1:0]));
   assign w_f3ok = mem_write_ex_i ? (~funct3_ex_i[2] & (funct3_ex_i[1:0] != 2'b11))
                                  : ((funct3_ex_i[1:0] != 2'b11) & (funct3_ex_i[2:1] != 2'b11));
   assign w_legal = w_f3ok & ~w_mis;

   always_comb begin
      w_be    = 4'hf;
      w_wdata = 32'h0;
      if (mem_write_ex_i) begin
         w_be    = funct3_ex_i[1] ? 4'hf : funct3_ex_i[0] ? (alu_result_ex_i[1] ? 4'hc : 4'h3)
                                         : 4'b0001 << alu_result_ex_i[1:0];
         w_wdata = funct3_ex_i[1] ? write_data_ex_i : funct3_ex_i[0] ? {2{write_data_ex_i[15:0]}}
                                                                     : {4{write_data_ex_i[7:0]}};
      end
   end

   // funct3[2] selects zero extension; [1] selects full word
   always_comb begin
      w_shift = dmem_rdata_i >> {r_off, 3'b000};
      w_ext   = r_f3[1] ? w_shift
              : r_f3[0] ? {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]}
                        : {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]};
   end

   always_comb begin
      w_next = r_state;
      w_next = (r_state == S_IDLE) ? ((w_acc & w_legal) ? S_REQ : S_IDLE)
             : (r_state == S_REQ)  ? (dmem_gnt_i ? (r_we ? S_IDLE : S_WAIT) : S_REQ)
                                   : (dmem_rvalid_i ? S_IDLE : S_WAIT);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_addr       <= '0;
         r_off        <= '0;
         r_we         <= 1'b0;
         r_be         <= '0;
         r_wdata      <= '0;
         r_f3         <= '0;
         r_rd         <= '0;
         r_load_data  <= '0;
         r_rd_out     <= '0;
         r_load_valid <= 1'b0;
         r_store_done <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         if (w_acc & w_legal) begin
            r_addr  <= alu_result_ex_i[31:2];
            r_off   <= alu_result_ex_i[1:0];
            r_we    <= mem_write_ex_i;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_f3    <= funct3_ex_i;
            r_rd    <= rd_ex_i;
         end
         r_fault      <= w_acc & ~w_legal;
         r_store_done <= (r_state == S_REQ) & dmem_gnt_i & r_we;
         r_load_valid <= (r_state == S_WAIT) & dmem_rvalid_i;
         if ((r_state == S_WAIT) & dmem_rvalid_i) begin
            r_load_data <= w_ext;
            r_rd_out    <= r_rd;
         end
      end
   end

   assign dmem_req_o   = (r_state == S_REQ);
   assign dmem_we_o    = r_we;
   assign dmem_addr_o  = {r_addr, 2'b00};
   assign dmem_be_o    = r_be;
   assign dmem_wdata_o = r_wdata;
   assign load_data_o  = r_load_data;
   assign rd_o         = r_rd_out;
   assign load_valid_o = r_load_valid;
   assign store_done_o = r_store_done;
   assign fault_o      = r_fault;
   assign stall_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with expected bus requests and
// responses queued up front, checked by an independent monitor.
module tb_load_store_unit;
   logic        clk = 0;
   logic        reset_n = 0;
   logic        valid = 0, mrd = 0, mwr = 0, flush = 0;
   logic [2:0]  f3 = 0;
   logic [31:0] addr = 0, wd = 0;
   logic [4:0]  rd = 0;
   logic        req, we, gnt = 0, rvalid = 0;
   logic [31:0] daddr, dwdata, rdata = 0, ldata;
   logic [3:0]  be;
   logic [4:0]  rdo;
   logic        lv, sd, flt, stall;

   int unsigned n_cmp = 0, n_bad = 0;
   int          n_stall = 0, n_req = 0, n_lv = 0;
   logic [68:0] bus_q[$];
   logic [38:0] resp_q[$];
   logic [68:0] cur_bus = '0;
   logic        prev_req = 0;

   load_store_unit dut (
      .clk_i(clk), .reset_n_i(reset_n), .valid_ex_i(valid), .mem_read_ex_i(mrd),
      .mem_write_ex_i(mwr), .funct3_ex_i(f3), .alu_result_ex_i(addr), .write_data_ex_i(wd),
      .rd_ex_i(rd), .flush_i(flush), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr),
      .dmem_be_o(be), .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
      .dmem_rdata_i(rdata), .load_data_o(ldata), .rd_o(rdo), .load_valid_o(lv),
      .store_done_o(sd), .fault_o(flt), .stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pop_resp(input string name, input logic [38:0] act);
      logic [38:0] e;
      if (resp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s unexpected actual=%0h", name, act);
      end else begin
         e = resp_q.pop_front();
         chk(name, {89'b0, act}, {89'b0, e});
      end
   endtask

   always @(negedge clk) begin
      if (stall) n_stall++;
      if (req) n_req++;
      if (lv) n_lv++;
      if (req) begin
         if (!prev_req) begin
            if (bus_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL bus_unexpected addr=%0h", daddr);
            end else cur_bus = bus_q.pop_front();
         end
         chk("bus", {59'b0, we, be, daddr, dwdata}, {59'b0, cur_bus});
      end
      prev_req = req;
      if (lv)  pop_resp("load_resp",  {2'd1, ldata, rdo});
      if (sd)  pop_resp("store_resp", {2'd2, 37'b0});
      if (flt) pop_resp("fault_resp", {2'd3, 37'b0});
   end

   task automatic op(input logic w, input logic [2:0] fc, input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] r, input int gd, input logic [31:0] rdat, input logic fl,
                     input logic legal, input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input logic [31:0] e_ld);
      @(posedge clk); #1;
      valid = 1; mrd = ~w; mwr = w; f3 = fc; addr = a; wd = d; rd = r; flush = fl;
      n_stall = 0; n_req = 0;
      if (!fl) begin
         if (legal) begin
            bus_q.push_back({w, e_be, e_addr, e_wd});
            resp_q.push_back(w ? {2'd2, 37'b0} : {2'd1, e_ld, r});
         end else resp_q.push_back({2'd3, 37'b0});
      end
      @(posedge clk); #1;
      valid = 0; mrd = 0; mwr = 0; flush = 0;
      if (legal && !fl) begin
         repeat (gd) begin @(posedge clk); #1; end
         gnt = 1;
         @(posedge clk); #1;
         gnt = 0;
         if (!w) begin
            rdata = rdat; rvalid = 1;
            @(posedge clk); #1;
            rvalid = 0;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("reset_outputs", {17'b0, req, we, be, daddr, dwdata, ldata, rdo, lv, sd, flt, stall}, 128'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;

      op(0, 3'b010, 32'h100, 0, 5'd5, 0, 32'hDEADBEEF, 0, 1, 32'h100, 4'hf, 0, 32'hDEADBEEF);
      chk("lw_stall", n_stall, 2);
      chk("lw_req", n_req, 1);
      op(0, 3'b000, 32'h103, 0, 5'd6, 0, 32'h80123456, 0, 1, 32'h100, 4'hf, 0, 32'hFFFFFF80);
      chk("lb_hold", ldata, 32'hFFFFFF80);
      op(0, 3'b100, 32'h103, 0, 5'd7, 1, 32'h80123456, 0, 1, 32'h100, 4'hf, 0, 32'h00000080);
      chk("lbu_stall", n_stall, 3);
      op(0, 3'b001, 32'h102, 0, 5'd8, 0, 32'h80123456, 0, 1, 32'h100, 4'hf, 0, 32'hFFFF8012);
      op(0, 3'b101, 32'h102, 0, 5'd9, 0, 32'hBEEF1234, 0, 1, 32'h100, 4'hf, 0, 32'h0000BEEF);
      op(0, 3'b000, 32'h101, 0, 5'd10, 0, 32'h00007F00, 0, 1, 32'h100, 4'hf, 0, 32'h0000007F);

      op(1, 3'b001, 32'h202, 32'h0000ABCD, 0, 3, 0, 0, 1, 32'h200, 4'hc, 32'hABCDABCD, 0);
      chk("sh_stall", n_stall, 4);
      chk("sh_req", n_req, 4);
      op(1, 3'b000, 32'h301, 32'h12345678, 0, 1, 0, 0, 1, 32'h300, 4'h2, 32'h78787878, 0);
      chk("sb_stall", n_stall, 2);
      op(1, 3'b010, 32'h404, 32'hCAFEF00D, 0, 0, 0, 0, 1, 32'h404, 4'hf, 32'hCAFEF00D, 0);
      chk("sw_stall", n_stall, 1);

      op(0, 3'b010, 32'h101, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lw_mis_req", n_req, 0);
      chk("lw_mis_stall", n_stall, 0);
      op(1, 3'b001, 32'h003, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sh_mis_req", n_req, 0);
      chk("sh_mis_stall", n_stall, 0);
      op(0, 3'b011, 32'h0, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
      op(1, 3'b100, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("illegal_req", n_req, 0);

      op(0, 3'b010, 32'h100, 0, 5'd4, 0, 0, 1, 1, 0, 0, 0, 0);
      chk("flush_req", n_req, 0);
      chk("flush_stall", n_stall, 0);

      @(posedge clk); #1;
      valid = 1; mrd = 1; f3 = 3'b010; addr = 32'h500; rd = 5'd9;
      bus_q.push_back({1'b0, 4'hf, 32'h500, 32'h0});
      @(posedge clk); #1;
      valid = 0; mrd = 0; gnt = 1;
      @(posedge clk); #1;
      gnt = 0;
      chk("wait_stall", stall, 1);
      reset_n = 0;
      #1;
      chk("midreset_outputs", {17'b0, req, we, be, daddr, dwdata, ldata, rdo, lv, sd, flt, stall}, 128'b0);
      n_lv = 0;
      @(posedge clk); #1;
      reset_n = 1; rdata = 32'h12345678; rvalid = 1;
      @(posedge clk); #1;
      rvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("late_rvalid_lv", n_lv, 0);
      chk("late_rvalid_data", ldata, 0);

      op(0, 3'b010, 32'h104, 0, 5'd11, 0, 32'h11223344, 0, 1, 32'h104, 4'hf, 0, 32'h11223344);
      chk("post_reset_rd", rdo, 5'd11);

      chk("bus_q_left", bus_q.size(), 0);
      chk("resp_q_left", resp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access unit that sits directly after the execute stage and consumes its address, store data and load/store controls. Each captured load or store becomes exactly one transaction on a single-outstanding data-memory bus with a request/grant/response handshake. The unit performs byte-lane steering and load sign/zero extension. It holds the pipeline via a stall output while a transaction is in flight, and delivers formatted load data with its destination register toward writeback.

## Interface
No parameters; data path is fixed at 32 bits.
- clk_i  input  1  sole clock, all state updates on rising edge
- reset_n_i  input  1  asynchronous, active-low reset
- valid_ex_i  input  1  execute-stage instruction valid
- mem_read_ex_i  input  1  instruction is a load
- mem_write_ex_i  input  1  instruction is a store (mutually exclusive with mem_read_ex_i)
- funct3_ex_i  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_ex_i  input  32  effective byte address
- write_data_ex_i  input  32  store data (forwarded operand)
- rd_ex_i  input  5  load destination register
- flush_i  input  1  squash execute-stage instruction this cycle
- dmem_req_o  output  1  bus request
- dmem_we_o  output  1  1 = write, 0 = read
- dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_gnt_i  input  1  request accepted this cycle
- dmem_rvalid_i  input  1  read data valid this cycle
- dmem_rdata_i  input  32  read data word
- load_data_o  output  32  extended load result
- rd_o  output  5  destination of load_data_o
- load_valid_o  output  1  one-cycle pulse: load_data_o/rd_o valid
- store_done_o  output  1  one-cycle pulse: store granted
- fault_o  output  1  one-cycle pulse: misaligned or illegal-width access
- stall_o  output  1  upstream must hold the current execute instruction

## Operation
- Accept condition: state IDLE, valid_ex_i & (mem_read_ex_i | mem_write_ex_i) & ~flush_i.
- On accept, register the following: address, we, be, wdata, funct3, rd, and addr[1:0] for extraction.
- Legality check is applied at accept time:
  - H/HU/SH require addr[0]=0; W/SW require addr[1:0]=00.
  - Load funct3 011/110/111 is illegal. Store funct3 other than 000/001/010 is illegal.
  - An illegal access issues no request, leaves state IDLE, and pulses fault_o on the next cycle.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - SH: be = 4'b0011 << (2*addr[1]), wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111, wdata = d.
- Loads: dmem_be_o = 4'b1111 and dmem_wdata_o = 0.
- Load extraction: shift dmem_rdata_i right by 8*addr[1:0], then apply B/H sign extension or BU/HU zero extension. W passes the word unchanged.
- FSM states and transitions:
  - IDLE: on a legal accept, go to REQ.
  - REQ: dmem_req_o=1 with all bus outputs stable. When dmem_gnt_i=1, a store goes to IDLE and a load goes to WAIT.
  - WAIT: dmem_req_o=0. When dmem_rvalid_i=1, go to IDLE.
- stall_o = (state != IDLE), combinational.
- Bus rules:
  - One transaction is outstanding at most.
  - dmem_rvalid_i is only legal in WAIT. It is ignored in other states.
  - dmem_rvalid_i never arrives in the grant cycle.
- flush_i affects only the capture decision in IDLE. A transaction already in REQ or WAIT always completes, because a request is never withdrawn before grant.
- Any valid_ex_i that is not a memory op is ignored.

## Timing
- Reset (async assert) drives all outputs to 0 and the state to IDLE immediately, including mid-transaction. A pending response is discarded.
- Accept at edge N → dmem_req_o high from cycle N+1.
- Store granted in cycle G → store_done_o pulses in cycle G+1, stall_o falls in G+1, and the next op can be accepted at edge G+1.
- Load rvalid in cycle R → load_valid_o, load_data_o and rd_o are registered at edge R, i.e. valid during cycle R+1. stall_o falls in R+1.
  - Minimum load latency is accept edge N → data valid in cycle N+3 (gnt in N+1, rvalid in N+2).
- load_data_o and rd_o hold their last value between pulses.
- The fault_o pulse occurs in cycle N+1 and stall_o is never asserted for it.

## Test plan
- LW at 0x100, gnt in the first REQ cycle, rdata 0xDEADBEEF one cycle later:
  - Bus: dmem_addr_o=0x100, be=1111, we=0.
  - Result: load_valid_o pulses with 0xDEADBEEF and rd; stall_o high for exactly 2 cycles.
- LB at 0x103 and LBU at 0x103, each with rdata 0x80123456:
  - LB → load_data_o = 0xFFFFFF80.
  - LBU → load_data_o = 0x00000080.
- SH at 0x202 with data 0x0000ABCD and gnt delayed 3 cycles:
  - req, addr=0x200, be=1100, wdata=0xABCDABCD held stable for all 4 REQ cycles.
  - store_done_o pulses once.
- LW at 0x101 and SH at 0x003:
  - No dmem_req_o; fault_o pulses 1 cycle each; stall_o stays 0.
- Squash and mid-load reset:
  - flush_i with a valid LW in IDLE → no request.
  - Reset_n_i low during WAIT → outputs 0 immediately.
  - A late rvalid after reset release → ignored, no load_valid_o.
